// File: rtl/crc24_framer.sv
// CRC-24A block framer.
// Accepts a serial payload, forwards it one cycle later, then appends the
// 24-bit CRC MSB first, and holds the block open until the interleaver
// reports done.
//
// Handshake: a payload bit is consumed on a rising edge where
// in_valid & in_ready are both high; out_valid marks each cycle in which
// out_data carries a block bit. There is no backpressure on the output side.
module crc24_framer #(
   parameter int          SMALL_K = 1056,
   parameter int          LARGE_K = 6144,
   parameter logic [23:0] POLY    = 24'h864CFB
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic       size_sel,
   input  logic       in_valid,
   input  logic       in_data,
   output logic       in_ready,
   output logic       crc_start,
   output logic       block_size,
   output logic       out_valid,
   output logic       out_data,
   output logic       crc_end,
   input  logic       intl_done,
   output logic       busy,
   output logic [2:0] state_dbg
);

   // Payload length (in bits) for each block size.
   localparam logic [12:0] SMALL_LIM = 13'(SMALL_K - 24);
   localparam logic [12:0] LARGE_LIM = 13'(LARGE_K - 24);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_PAYLOAD   = 3'd2,
      S_CRC       = 3'd3,
      S_WAIT_DONE = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [23:0] crc_q;
   logic [12:0] cnt_q;
   logic [12:0] cnt_inc;
   logic [12:0] limit;
   logic        accept;
   logic        last_payload;
   logic        fb;
   logic [23:0] crc_upd;
   logic        block_size_q;
   logic        out_valid_q;
   logic        out_data_q;
   logic        crc_end_q;

   assign limit        = block_size_q ? LARGE_LIM : SMALL_LIM;
   assign cnt_inc      = cnt_q + 13'd1;
   assign accept       = in_valid & in_ready;
   assign last_payload = accept && (cnt_inc == limit);
   assign fb           = crc_q[23] ^ in_data;
   assign crc_upd      = {crc_q[22:0], 1'b0} ^ (fb ? POLY : 24'd0);

   assign block_size = block_size_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign crc_end    = crc_end_q;
   assign state_dbg  = state;

   // State register; reset drops straight back to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode and state-derived control outputs.
   // CRC occupies 25 cycles: the first one drains the last payload bit from
   // the output register while the first CRC bit is loaded behind it.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      crc_start = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (go) state_nxt = S_START;
         end
         S_START: begin
            crc_start = 1'b1;
            state_nxt = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            in_ready = 1'b1;
            if (last_payload) state_nxt = S_CRC;
         end
         S_CRC: begin
            if (cnt_q == 13'd24) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (intl_done) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: size latch, CRC register, bit counter and registered output bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         block_size_q <= 1'b0;
         crc_q        <= 24'd0;
         cnt_q        <= 13'd0;
         out_valid_q  <= 1'b0;
         out_data_q   <= 1'b0;
         crc_end_q    <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
         crc_end_q   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go) begin
                  block_size_q <= size_sel;
                  crc_q        <= 24'd0;
                  cnt_q        <= 13'd0;
               end
            end
            S_PAYLOAD: begin
               if (accept) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= in_data;
                  crc_q       <= crc_upd;
                  // The counter is reused to pace the CRC bits.
                  cnt_q       <= last_payload ? 13'd0 : cnt_inc;
               end
            end
            S_CRC: begin
               if (cnt_q < 13'd24) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= crc_q[23];
                  crc_q       <= {crc_q[22:0], 1'b0};
                  crc_end_q   <= (cnt_q == 13'd23);
                  cnt_q       <= cnt_inc;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
